// File: rtl/tele_frame_tx.sv
// tele_frame_tx: queues {addr,data} frames in a small FIFO and shifts each out as
// start, addr[0..6], data[0..3], even parity, stop, one bit per CLKS_PER_BIT clocks.
module tele_frame_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic [6:0] i_addr,
  input  logic [3:0] i_data,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_sent_flag,
  output logic [6:0] o_sent_addr,
  output logic [4:0] o_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [4:0] FULL = 5'(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, START, ADDR, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic [10:0] mem [FIFO_DEPTH];
  logic [10:0] head;
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0] pos, pos_n;
  logic [11:0] frame;
  logic push, pop, tick, done, tx_n;
  assign o_ready = o_level < FULL;
  assign o_busy = state != IDLE;
  assign push = i_valid && o_ready;
  assign pop = state == IDLE && o_level != 5'd0;
  assign tick = cnt == LAST;
  assign head = mem[rptr];
  always_comb begin
    state_n = state;
    done = 1'b0;
    case (state)
      IDLE:    state_n = pop ? START : IDLE;
      START:   state_n = tick ? ADDR : START;
      ADDR:    state_n = tick && pos == 4'd6 ? DATA : ADDR;
      DATA:    state_n = tick && pos == 4'd10 ? PARITY : DATA;
      PARITY:  state_n = tick ? STOP : PARITY;
      STOP: begin
        state_n = tick ? IDLE : STOP;
        done = tick;
      end
      default: state_n = IDLE;
    endcase
    cnt_n = tick || state == IDLE ? '0 : cnt + 1'b1;
    pos_n = state == IDLE ? 4'd0 : (state == ADDR || state == DATA) && tick ? pos + 4'd1 : pos;
    // o_tx is registered, so it is computed from the state being entered
    tx_n = state_n == START ? 1'b0 :
           (state_n == ADDR || state_n == DATA || state_n == PARITY) ? frame[pos_n] : 1'b1;
  end
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      cnt <= '0;
      pos <= '0;
      frame <= '0;
      wptr <= '0;
      rptr <= '0;
      o_level <= '0;
      o_tx <= 1'b1;
      o_sent_flag <= 1'b0;
      o_sent_addr <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      pos <= pos_n;
      o_tx <= tx_n;
      o_sent_flag <= done;
      if (done) o_sent_addr <= frame[6:0];
      if (pop) frame <= {^head, head[3:0], head[10:4]};
      if (pop) rptr <= rptr + 1'b1;
      if (push) wptr <= wptr + 1'b1;
      o_level <= o_level + 5'(push) - 5'(pop);
    end
  end
  always_ff @(posedge Clock)
    if (push) mem[wptr] <= {i_addr, i_data};
endmodule

// File: tb/tb_tele_frame_tx.sv
// tb_tele_frame_tx: random and directed frames, checked by a line-decoding scoreboard.
module tb_tele_frame_tx;
  localparam int C = 16;
  localparam int D = 4;
  localparam int P = 10;
  logic Clock = 1'b0;
  logic Reset, i_valid, o_ready, o_tx, o_busy, o_sent_flag;
  logic [6:0] i_addr, o_sent_addr;
  logic [3:0] i_data;
  logic [4:0] o_level;
  int total = 0, bad = 0;
  int pushes = 0, starts = 0, k = 0;
  bit in_frame = 0, ok = 1;
  logic [10:0] sb [$];
  logic [10:0] cur;
  logic [13:0] exp_f;

  tele_frame_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .Clock(Clock), .Reset(Reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_addr(i_addr), .i_data(i_data), .o_tx(o_tx), .o_busy(o_busy),
    .o_sent_flag(o_sent_flag), .o_sent_addr(o_sent_addr), .o_level(o_level)
  );

  always #(P/2) Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: expected frame = {stop, even parity, data, addr, start}, LSB sent first.
  initial forever begin
    @(posedge Clock);
    if (Reset && i_valid && pushes - starts < D) begin
      sb.push_back({i_addr, i_data});
      pushes++;
    end
    @(negedge Clock);
    if (!Reset) begin
      check("rst_tx", o_tx, 1);
      check("rst_busy", o_busy, 0);
      check("rst_flag", o_sent_flag, 0);
      check("rst_level", o_level, 0);
      check("rst_sent_addr", o_sent_addr, 0);
      sb.delete();
      pushes = 0;
      starts = 0;
      in_frame = 0;
    end else begin
      if (!in_frame) begin
        check("idle_flag", o_sent_flag, 0);
        if (!o_tx) begin
          starts++;
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL start_without_push: got start bit expected idle at %0t", $time);
            cur = '0;
          end else cur = sb.pop_front();
          exp_f = {1'b1, ^cur, cur[3:0], cur[10:4], 1'b0};
          k = 0;
          ok = 1;
          in_frame = 1;
        end
      end
      if (in_frame) begin
        if (k < 14 * C) begin
          if (o_tx !== exp_f[k / C] || o_busy !== 1'b1 || o_sent_flag !== 1'b0) ok = 0;
          if (k % C == C - 1) begin
            check($sformatf("frame_addr%0h_bit%0d", cur[10:4], k / C), {31'b0, ok}, 1);
            ok = 1;
          end
          k++;
        end else begin
          check("sent_flag", o_sent_flag, 1);
          check("sent_addr", o_sent_addr, cur[10:4]);
          check("busy_after", o_busy, 0);
          in_frame = 0;
        end
      end
      check("level", o_level, pushes - starts);
      check("ready", o_ready, pushes - starts < D);
    end
  end

  task automatic send(input logic [6:0] a, input logic [3:0] d);
    logic acc;
    int n = 0;
    i_valid = 1;
    i_addr = a;
    i_data = d;
    forever begin
      acc = o_ready;
      @(posedge Clock);
      #1;
      if (acc) break;
      if (++n > 2000) begin
        total++;
        bad++;
        $display("FAIL push_timeout: got no accept expected accept for addr %0h", a);
        break;
      end
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((o_busy || o_level != 0) && n < 5000) begin
      @(negedge Clock);
      n++;
    end
    check("idle_timeout", n < 5000, 1);
    repeat (3) @(negedge Clock);
  endtask

  initial begin
    longint t0;
    int n;
    Reset = 0;
    i_valid = 0;
    i_addr = 0;
    i_data = 0;
    repeat (3) @(negedge Clock);
    #1 Reset = 1;
    send(7'h55, 4'h9);
    i_valid = 0;
    wait_idle();
    send(7'h01, 4'h0);
    i_valid = 0;
    wait_idle();
    for (int i = 0; i < 6; i++) send(7'h10 + 7'(i), 4'(i));
    i_valid = 0;
    wait_idle();
    send(7'h20, 4'h5);
    i_valid = 0;
    n = 0;
    while (o_tx && n < 100) begin
      @(negedge Clock);
      n++;
    end
    check("start_timeout", n < 100, 1);
    t0 = $time;
    send(7'h21, 4'h5);
    send(7'h22, 4'h5);
    i_valid = 0;
    while ($time < t0 + 9 * C * P) @(negedge Clock);
    check("tx_data1_before_rst", o_tx, 0);
    check("level_before_rst", o_level, 2);
    #2 Reset = 0;
    #1;
    check("async_rst_tx", o_tx, 1);
    check("async_rst_level", o_level, 0);
    check("async_rst_busy", o_busy, 0);
    repeat (3) @(negedge Clock);
    #1 Reset = 1;
    send(7'h3c, 4'ha);
    i_valid = 0;
    wait_idle();
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 300)) @(negedge Clock);
      #1;
      send(7'($urandom), 4'($urandom));
      i_valid = 0;
    end
    wait_idle();
    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish expected finish by %0t", $time);
    $fatal(1);
  end
endmodule
